// File: rtl/sprite_line_engine_if.sv
// sprite_line_engine_if: OAM read port and VRAM pattern-fetch req/ack port of the sprite engine
interface sprite_line_engine_if #(parameter int IDX_W = 6);
  logic [IDX_W-1:0] oam_rd_idx;
  logic [31:0]      oam_rd_data;
  logic             vram_req;
  logic [11:0]      vram_addr;
  logic             vram_bank;
  logic             vram_ack;
  logic [7:0]       vram_data;
  modport master(output oam_rd_idx, vram_req, vram_addr, vram_bank, input oam_rd_data, vram_ack, vram_data);
  modport slave(input oam_rd_idx, vram_req, vram_addr, vram_bank, output oam_rd_data, vram_ack, vram_data);
endinterface

// File: rtl/sprite_line_engine.sv
// sprite_line_engine: per-scanline OAM scan, pattern fetch and DMG/GBC sprite pixel priority
module sprite_line_engine #(
  parameter int OAM_ENTRIES = 40,
  parameter int SLOTS       = 10,
  parameter int IDX_W       = 6
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       size16,
  input  logic       isGBC,
  input  logic       line_start,
  input  logic [7:0] v_cnt,
  input  logic [7:0] h_cnt,
  sprite_line_engine_if.master bus,
  output logic [3:0] sprite_count,
  output logic       ready,
  output logic       pixel_active,
  output logic       pixel_prio,
  output logic       pixel_cmap,
  output logic [1:0] pixel_data,
  output logic [2:0] pixel_cmap_gbc
);
  typedef enum logic [2:0] {IDLE, SCAN, FETCH_LO, FETCH_HI, READY} state_t;
  state_t r_state, w_next;
  logic [7:0]       r_line_y;
  logic [IDX_W-1:0] r_idx;
  logic             r_eval_v, r_eval_last;
  logic [3:0]       r_count, r_k;
  logic [7:0]       r_x [SLOTS];
  logic [7:0]       r_tile [SLOTS];
  logic [6:0]       r_attr [SLOTS];
  logic [3:0]       r_row [SLOTS];
  logic [7:0]       r_p0 [SLOTS];
  logic [7:0]       r_p1 [SLOTS];
  logic [7:0]  w_flags, w_tile, w_x, w_y, w_ktile, w_wx;
  logic [8:0]  w_ly16;
  logic [3:0]  w_dy, w_row, w_krow, w_count_nx;
  logic [10:0] w_trow;
  logic [1:0]  w_wpix;
  logic [2:0]  w_wgbc;
  logic        w_vis, w_store, w_scan_done, w_fetch, w_kbank, w_found, w_wprio, w_wcmap, w_show;
  assign {w_flags, w_tile, w_x, w_y} = bus.oam_rd_data;
  assign w_ly16      = {1'b0, r_line_y} + 9'd16;
  assign w_vis       = w_ly16 >= {1'b0, w_y} && w_ly16 < {1'b0, w_y} + (size16 ? 9'd16 : 9'd8);
  assign w_dy        = r_line_y[3:0] - w_y[3:0];
  assign w_row       = w_flags[6] ? ~w_dy : w_dy;
  assign w_store     = r_state == SCAN && r_eval_v && w_vis && r_count < 4'(SLOTS);
  assign w_scan_done = r_state == SCAN && r_eval_v && (r_eval_last || (w_store && r_count == 4'(SLOTS - 1)));
  assign w_count_nx  = r_count + {3'b0, w_store};
  assign w_trow      = size16 ? {w_ktile[7:1], w_krow} : {w_ktile, w_krow[2:0]};
  assign bus.oam_rd_idx = r_idx;
  assign sprite_count   = r_count;
  always_comb begin
    w_ktile = '0;
    w_krow  = '0;
    w_kbank = 1'b0;
    for (int s = 0; s < SLOTS; s++)
      if (r_k == 4'(s)) begin
        w_ktile = r_tile[s];
        w_krow  = r_row[s];
        w_kbank = r_attr[s][3];
      end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    if (line_start) w_next = SCAN;
    else
      case (r_state)
        SCAN:     if (w_scan_done) w_next = w_count_nx != 4'd0 ? FETCH_LO : READY;
        FETCH_LO: if (bus.vram_ack) w_next = FETCH_HI;
        FETCH_HI: if (bus.vram_ack) w_next = r_k == r_count - 4'd1 ? READY : FETCH_LO;
        default:  w_next = r_state;
      endcase
  end
  always_comb begin
    w_fetch       = r_state == FETCH_LO || r_state == FETCH_HI;
    bus.vram_req  = w_fetch;
    bus.vram_addr = w_fetch ? {w_trow, r_state == FETCH_HI} : 12'h0;
    bus.vram_bank = w_fetch & isGBC & w_kbank;
    ready         = r_state == READY;
  end
  // the OAM entry evaluated in a cycle is the one requested in the previous cycle
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_line_y    <= '0;
      r_idx       <= '0;
      r_eval_v    <= 1'b0;
      r_eval_last <= 1'b0;
      r_count     <= '0;
      r_k         <= '0;
      for (int s = 0; s < SLOTS; s++) begin
        r_x[s]    <= '0;
        r_tile[s] <= '0;
        r_attr[s] <= '0;
        r_row[s]  <= '0;
        r_p0[s]   <= '0;
        r_p1[s]   <= '0;
      end
    end else if (line_start) begin
      r_line_y    <= v_cnt;
      r_idx       <= '0;
      r_eval_v    <= 1'b0;
      r_eval_last <= 1'b0;
      r_count     <= '0;
      r_k         <= '0;
    end else begin
      if (r_state == SCAN) begin
        r_idx       <= r_idx + IDX_W'(1);
        r_eval_v    <= 1'b1;
        r_eval_last <= r_idx == IDX_W'(OAM_ENTRIES - 1);
        r_count     <= w_count_nx;
      end
      if (r_state == FETCH_HI && bus.vram_ack) r_k <= r_k + 4'd1;
      for (int s = 0; s < SLOTS; s++) begin
        if (w_store && r_count == 4'(s)) begin
          r_x[s]    <= w_x;
          r_tile[s] <= w_tile;
          r_attr[s] <= {w_flags[7], w_flags[5:0]};
          r_row[s]  <= w_row;
        end
        if (bus.vram_ack && r_k == 4'(s) && r_state == FETCH_LO) r_p0[s] <= bus.vram_data;
        if (bus.vram_ack && r_k == 4'(s) && r_state == FETCH_HI) r_p1[s] <= bus.vram_data;
      end
    end
  // ascending slot walk: first candidate wins for GBC, strictly smaller x overrides for DMG
  always_comb begin : pick
    logic [2:0] d, col;
    logic [1:0] pix;
    d       = '0;
    col     = '0;
    pix     = '0;
    w_found = 1'b0;
    w_wx    = 8'hFF;
    w_wpix  = '0;
    w_wprio = 1'b0;
    w_wcmap = 1'b0;
    w_wgbc  = '0;
    for (int s = 0; s < SLOTS; s++) begin
      d   = h_cnt[2:0] - r_x[s][2:0];
      col = r_attr[s][5] ? d : ~d;
      pix = {r_p1[s][col], r_p0[s][col]};
      if (r_count > 4'(s) && {1'b0, h_cnt} + 9'd8 >= {1'b0, r_x[s]} && h_cnt < r_x[s] && pix != 2'b0 &&
          (!w_found || (!isGBC && r_x[s] < w_wx))) begin
        w_found = 1'b1;
        w_wx    = r_x[s];
        w_wpix  = pix;
        w_wprio = r_attr[s][6];
        w_wcmap = r_attr[s][4];
        w_wgbc  = r_attr[s][2:0];
      end
    end
  end
  assign w_show = r_state == READY && w_found;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      pixel_active   <= 1'b0;
      pixel_data     <= '0;
      pixel_prio     <= 1'b0;
      pixel_cmap     <= 1'b0;
      pixel_cmap_gbc <= '0;
    end else begin
      pixel_active   <= w_show;
      pixel_data     <= w_show ? w_wpix : 2'b0;
      pixel_prio     <= w_show & w_wprio;
      pixel_cmap     <= w_show & w_wcmap;
      pixel_cmap_gbc <= w_show ? w_wgbc : 3'b0;
    end
endmodule

// File: doc/sprite_line_engine.md
# sprite_line_engine

Parametrised per-scanline sprite engine for the PPU. It replaces the bank of independent per-sprite units with one block that:
- scans OAM at line start and selects up to SLOTS visible sprites in OAM order;
- fetches each selected sprite's two pattern bytes over a req/ack VRAM port;
- resolves DMG or GBC priority per pixel and presents one registered sprite pixel to the PPU mixer.

## Interface
Parameters:
- OAM_ENTRIES, 40, number of OAM entries scanned per line
- SLOTS, 10, maximum sprites kept per line
- IDX_W, 6, OAM index width; must satisfy 2**IDX_W >= OAM_ENTRIES

Ports:
- clk  in  1  PPU clock; single clock domain
- reset_n  in  1  asynchronous, active-low reset
- size16  in  1  1 = 8x16 sprites
- isGBC  in  1  1 = GBC priority and bank select
- line_start  in  1  one-cycle pulse; latches v_cnt and starts a scan
- v_cnt  in  8  current line
- h_cnt  in  8  current pixel column
- oam_rd_idx  out  IDX_W  OAM entry requested
- oam_rd_data  in  32  {flags,tile,x,y} of the entry requested in the previous cycle
- vram_req  out  1  fetch request
- vram_addr  out  12  {tile-row address[10:0], plane}
- vram_bank  out  1  isGBC & flags[3]
- vram_ack  in  1  vram_data valid this cycle
- vram_data  in  8  pattern byte
- sprite_count  out  4  number of sprites selected this line
- ready  out  1  fetch complete; pixel outputs are valid
- pixel_active, pixel_prio, pixel_cmap  out  1 each  winning pixel is non-zero / flags[7] / flags[4]
- pixel_data  out  2  winning colour index
- pixel_cmap_gbc  out  3  flags[2:0] of the winner

## Operation
- States: IDLE, SCAN, FETCH_LO, FETCH_HI, READY.
- Reset values:
  - state IDLE; oam_rd_idx 0; vram_req 0; vram_addr 0; vram_bank 0; sprite_count 0; ready 0.
  - All pixel outputs 0. Slot registers cleared.
- line_start in any state:
  - Latches v_cnt into line_y, clears sprite_count and ready, drops vram_req, sets oam_rd_idx=0, enters SCAN.
  - Any in-flight fetch is abandoned; a vram_ack arriving after the abort is ignored.
- SCAN:
  - oam_rd_idx increments every cycle; the entry returned one cycle later is evaluated.
  - Visibility uses 9-bit arithmetic, no wrap: line_y+16 >= y and line_y+16 < y+height, where height is 16 if size16 else 8.
  - A visible entry with sprite_count < SLOTS is stored in slot[sprite_count] as {x, tile, flags, row}; sprite_count then increments.
  - row = flags[6] ? ~(line_y-y)[3:0] : (line_y-y)[3:0].
  - SCAN ends after entry OAM_ENTRIES-1 is evaluated, or when sprite_count reaches SLOTS (early exit).
  - Exit goes to FETCH_LO with k=0 if sprite_count>0, else directly to READY.
- FETCH_LO / FETCH_HI for slot k:
  - Tile-row address is {tile,row[2:0]} for 8-pixel sprites, {tile[7:1],row[3:0]} for size16.
  - vram_addr = {tile-row address, 0} in FETCH_LO, {tile-row address, 1} in FETCH_HI.
  - vram_req is held high with address and bank stable until vram_ack is seen.
  - On ack, vram_data is latched into the slot's plane 0 or plane 1 register.
  - FETCH_LO goes to FETCH_HI; FETCH_HI increments k.
  - After k = sprite_count-1 completes FETCH_HI: vram_req drops and the block enters READY with ready=1.
- READY, per slot, combinational:
  - hit = h_cnt+8 >= x and h_cnt < x, 9-bit compare.
  - c = (h_cnt-x)[2:0]; col = flags[5] ? c : ~c.
  - pix = {plane1[col], plane0[col]}; candidate = hit & pix!=0.
- Priority:
  - isGBC=1: the lowest slot among candidates wins (slot order is OAM order).
  - isGBC=0: the smallest x wins; ties go to the lowest slot.
- Winner attributes are registered into the pixel outputs every cycle. With no candidate, or when not in READY, pixel_active=0 and pixel_data=0.
- An OAM write during SCAN is the caller's problem; the block uses whatever data is returned.

## Timing
- Scan latency: OAM_ENTRIES+1 cycles from line_start to leaving SCAN, or fewer on early exit.
- Fetch: 2 requests per sprite; each completes in the ack cycle. The next request is asserted on the cycle after an ack, never in the same cycle.
- ready rises on the cycle after the last ack. With 0 sprites, ready rises OAM_ENTRIES+2 cycles after line_start.
- Pixel outputs have 1-cycle latency from h_cnt.
- line_start coinciding with vram_ack: line_start wins and the data is discarded.

## Test plan
- 1 sprite at OAM 5: y=20, x=16, tile=0x12, flags=0, v_cnt=6; VRAM returns 0xF0 then 0x0F -> sprite_count=1.
  - vram_addr = {0x12,3'd2,0} then {…,1}.
  - At h_cnt=8..11 pixel_data=1; at 12..15 pixel_data=2; pixel_active=0 at h_cnt=16.
- 12 visible sprites on one line, SLOTS=10 -> sprite_count=10; only OAM 0..9 are fetched; the scan exits early; exactly 20 requests.
- Two overlapping sprites, OAM 3 at x=20 and OAM 7 at x=18:
  - isGBC=0 -> OAM 7 wins at h_cnt=12.
  - isGBC=1 -> OAM 3 wins.
- size16=1, flags[6]=1, tile=0x13, line_y-y=0 -> row=15; vram_addr[11:1] = {0x09,4'hF}.
- Random-latency acks of 0-5 cycles -> vram_addr is stable while vram_req is high and the data lands in the correct plane.
- Two reset/abort cases:
  - line_start mid-FETCH_HI -> vram_req=0 next cycle, a new scan starts, and a late ack is ignored.
  - reset_n low at any time -> all outputs 0 immediately.
